// File: rtl/regfile_wb.sv
// regfile_wb: register file with per-register busy scoreboard, write-back bypass
// and a one-cycle registered dual-operand read port.
module regfile_wb #(
    parameter int WIDTH = 32,
    parameter int NREGS = 64
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_wr,
    input  logic [5:0]       i_rd,
    input  logic [WIDTH-1:0] i_val,
    input  logic             i_rd_en,
    input  logic [5:0]       i_rb,
    input  logic [5:0]       i_rc,
    input  logic             i_issue,
    input  logic [5:0]       i_issue_rd,
    output logic [WIDTH-1:0] o_b,
    output logic [WIDTH-1:0] o_c,
    output logic             o_valid,
    output logic             o_stall
);
    logic [WIDTH-1:0] regs [NREGS];
    logic [NREGS-1:0] busy;
    logic [NREGS-1:0] busy_next;
    logic             wr_live;
    logic             pend_b;
    logic             pend_c;
    logic             accept;
    logic [WIDTH-1:0] val_b;
    logic [WIDTH-1:0] val_c;

    assign wr_live = i_wr && i_rd != '0;
    // A write-back landing this cycle resolves the hazard on its register.
    assign pend_b  = busy[i_rb] && !(i_wr && i_rd == i_rb);
    assign pend_c  = busy[i_rc] && !(i_wr && i_rd == i_rc);
    assign o_stall = i_rd_en && (pend_b || pend_c);
    assign accept  = i_rd_en && !o_stall;
    assign val_b   = (wr_live && i_rd == i_rb) ? i_val : regs[i_rb];
    assign val_c   = (wr_live && i_rd == i_rc) ? i_val : regs[i_rc];

    // Clear first, then set, so an issue to the same register wins.
    always_comb begin
        busy_next = busy;
        if (i_wr) busy_next[i_rd] = 1'b0;
        if (i_issue) busy_next[i_issue_rd] = 1'b1;
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
            busy    <= '0;
            o_b     <= '0;
            o_c     <= '0;
            o_valid <= 1'b0;
        end else begin
            if (wr_live) regs[i_rd] <= i_val;
            busy    <= busy_next;
            o_valid <= accept;
            if (accept) begin
                o_b <= val_b;
                o_c <= val_c;
            end
        end
    end
endmodule

// File: tb/tb_regfile_wb.sv
// tb_regfile_wb: directed table-driven check of regfile_wb plus a hand-built
// reset-mid-operation sequence.
module tb_regfile_wb;
    typedef struct {
        logic        rst;
        logic        wr;
        logic [5:0]  rd;
        logic [31:0] val;
        logic        rd_en;
        logic [5:0]  rb;
        logic [5:0]  rc;
        logic        issue;
        logic [5:0]  issue_rd;
        logic        stall;
        logic [31:0] b;
        logic [31:0] c;
        logic        v;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst, wr, rd_en, issue;
    logic [5:0]  rd, rb, rc, issue_rd;
    logic [31:0] val;
    logic [31:0] o_b, o_c;
    logic        o_valid, o_stall;
    int          n_chk = 0;
    int          n_fail = 0;
    vec_t        tbl [20];

    always #5 clk = ~clk;

    regfile_wb #(.WIDTH(32), .NREGS(64)) dut (
        .i_clk(clk), .i_rst(rst), .i_wr(wr), .i_rd(rd), .i_val(val),
        .i_rd_en(rd_en), .i_rb(rb), .i_rc(rc), .i_issue(issue),
        .i_issue_rd(issue_rd), .o_b(o_b), .o_c(o_c), .o_valid(o_valid),
        .o_stall(o_stall)
    );

    function automatic vec_t mk(input logic r, input logic w, input logic [5:0] d,
                                input logic [31:0] x, input logic e, input logic [5:0] b_i,
                                input logic [5:0] c_i, input logic s, input logic [5:0] sd,
                                input logic st, input logic [31:0] eb, input logic [31:0] ec,
                                input logic ev);
        vec_t t;
        t.rst = r; t.wr = w; t.rd = d; t.val = x; t.rd_en = e; t.rb = b_i; t.rc = c_i;
        t.issue = s; t.issue_rd = sd; t.stall = st; t.b = eb; t.c = ec; t.v = ev;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle: check combinational stall mid-cycle, then registered outputs after the edge.
    task automatic apply(input string tag, input vec_t t);
        rst = t.rst; wr = t.wr; rd = t.rd; val = t.val; rd_en = t.rd_en;
        rb = t.rb; rc = t.rc; issue = t.issue; issue_rd = t.issue_rd;
        #3;
        chk({tag, " stall"}, {31'b0, o_stall}, {31'b0, t.stall});
        @(posedge clk);
        #1;
        chk({tag, " o_b"}, o_b, t.b);
        chk({tag, " o_c"}, o_c, t.c);
        chk({tag, " o_valid"}, {31'b0, o_valid}, {31'b0, t.v});
    endtask

    initial begin
        //            rst wr rd  val           en rb rc iss ird  stall b             c             v
        tbl[0]  = mk(1, 0, 0,  32'h0,        0, 0, 0, 0, 0,   0, 32'h0,        32'h0,        0);
        tbl[1]  = mk(0, 1, 5,  32'hDEADBEEF, 0, 0, 0, 0, 0,   0, 32'h0,        32'h0,        0);
        tbl[2]  = mk(0, 0, 0,  32'h0,        1, 5, 0, 0, 0,   0, 32'hDEADBEEF, 32'h0,        1);
        tbl[3]  = mk(0, 0, 0,  32'h0,        0, 0, 0, 0, 0,   0, 32'hDEADBEEF, 32'h0,        0);
        tbl[4]  = mk(0, 1, 7,  32'h12345678, 1, 7, 7, 0, 0,   0, 32'h12345678, 32'h12345678, 1);
        tbl[5]  = mk(0, 1, 0,  32'hFFFFFFFF, 0, 0, 0, 1, 0,   0, 32'h12345678, 32'h12345678, 0);
        tbl[6]  = mk(0, 0, 0,  32'h0,        1, 0, 7, 0, 0,   0, 32'h0,        32'h12345678, 1);
        tbl[7]  = mk(0, 0, 0,  32'h0,        1, 5, 7, 1, 3,   0, 32'hDEADBEEF, 32'h12345678, 1);
        tbl[8]  = mk(0, 0, 0,  32'h0,        1, 3, 0, 0, 0,   1, 32'hDEADBEEF, 32'h12345678, 0);
        tbl[9]  = mk(0, 0, 0,  32'h0,        1, 5, 3, 0, 0,   1, 32'hDEADBEEF, 32'h12345678, 0);
        tbl[10] = mk(0, 1, 3,  32'h55,       1, 3, 3, 0, 0,   0, 32'h55,       32'h55,       1);
        tbl[11] = mk(0, 1, 9,  32'hAA,       0, 0, 0, 1, 9,   0, 32'h55,       32'h55,       0);
        tbl[12] = mk(0, 0, 0,  32'h0,        1, 9, 0, 0, 0,   1, 32'h55,       32'h55,       0);
        tbl[13] = mk(0, 0, 0,  32'h0,        0, 9, 0, 0, 0,   0, 32'h55,       32'h55,       0);
        tbl[14] = mk(0, 1, 9,  32'h99,       1, 9, 5, 0, 0,   0, 32'h99,       32'hDEADBEEF, 1);
        tbl[15] = mk(0, 0, 0,  32'h0,        1, 9, 9, 0, 0,   0, 32'h99,       32'h99,       1);
        tbl[16] = mk(0, 1, 10, 32'hA0,       1, 10, 11, 1, 11, 0, 32'hA0,      32'h0,        1);
        tbl[17] = mk(0, 0, 0,  32'h0,        1, 11, 0, 0, 0,  1, 32'hA0,       32'h0,        0);
        tbl[18] = mk(0, 1, 11, 32'hB1,       0, 0, 0, 0, 0,   0, 32'hA0,       32'h0,        0);
        tbl[19] = mk(0, 0, 0,  32'h0,        1, 11, 10, 0, 0, 0, 32'hB1,       32'hA0,       1);

        @(posedge clk);
        #1;
        for (int i = 0; i < 20; i++) apply($sformatf("vec%0d", i), tbl[i]);

        // Reset mid-operation: registers 1..4 loaded, reg 2 busy, reset collides with write/read/issue.
        apply("rs_w1", mk(0, 1, 1, 32'h11, 0, 0, 0, 0, 0, 0, 32'hB1, 32'hA0, 0));
        apply("rs_w2", mk(0, 1, 2, 32'h22, 0, 0, 0, 0, 0, 0, 32'hB1, 32'hA0, 0));
        apply("rs_w3", mk(0, 1, 3, 32'h33, 0, 0, 0, 0, 0, 0, 32'hB1, 32'hA0, 0));
        apply("rs_w4", mk(0, 1, 4, 32'h44, 0, 0, 0, 1, 2, 0, 32'hB1, 32'hA0, 0));
        apply("rs_chk", mk(0, 0, 0, 32'h0, 1, 2, 1, 0, 0, 1, 32'hB1, 32'hA0, 0));
        apply("rs_rst", mk(1, 1, 1, 32'h77, 1, 1, 4, 1, 5, 0, 32'h0, 32'h0, 0));
        apply("rs_r12", mk(0, 0, 0, 32'h0, 1, 1, 2, 0, 0, 0, 32'h0, 32'h0, 1));
        apply("rs_r34", mk(0, 0, 0, 32'h0, 1, 3, 4, 0, 0, 0, 32'h0, 32'h0, 1));
        apply("rs_r5", mk(0, 0, 0, 32'h0, 1, 5, 2, 0, 0, 0, 32'h0, 32'h0, 1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
